dial_quad_encoder: RTL and testbench

//  Converts spinner (MiSTer-style) and joystick-button inputs into two 2-bit quadrature

---
 rtl/dial_pkg.sv | 36 +++
 rtl/dial_quad_encoder_if.sv | 33 +++
 rtl/dial_quad_channel.sv | 72 +++++++
 rtl/dial_quad_encoder.sv | 77 +++++++
 tb/tb_dial_quad_encoder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dial_pkg.sv
// Shared types and quadrature helpers for the spinner/joystick dial encoder.
package dial_pkg;

    typedef logic [1:0] quad_t;

    typedef enum logic [1:0] {
        StepNone,
        StepCw,
        StepCcw
    } step_t;

    // Gray-coded rotary sequence, indexed by phase 0..3
    localparam quad_t QUAD_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic logic [1:0] quad_index(quad_t q);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (QUAD_SEQ[i] == q) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic quad_t quad_next(quad_t q);
        logic [1:0] idx;
        idx = quad_index(q) + 2'd1;
        return QUAD_SEQ[idx];
    endfunction

    function automatic quad_t quad_prev(quad_t q);
        logic [1:0] idx;
        idx = quad_index(q) - 2'd1;
        return QUAD_SEQ[idx];
    endfunction

endpackage

// File: rtl/dial_quad_encoder_if.sv
// Input/output bundle of the dial encoder: line strobe, joysticks, spinners, dial outputs.
interface dial_quad_encoder_if;
    import dial_pkg::*;

    logic       LHBL;
    logic [6:0] joystick1;
    logic [6:0] joystick2;
    logic [8:0] spinner_1;
    logic [8:0] spinner_2;
    quad_t      dial_x;
    quad_t      dial_y;

    modport master (
        output LHBL,
        output joystick1,
        output joystick2,
        output spinner_1,
        output spinner_2,
        input  dial_x,
        input  dial_y
    );

    modport slave (
        input  LHBL,
        input  joystick1,
        input  joystick2,
        input  spinner_1,
        input  spinner_2,
        output dial_x,
        output dial_y
    );

endinterface

// File: rtl/dial_quad_channel.sv
// One dial axis: spinner toggle events and joystick rotate buttons -> 2-bit quadrature output.
module dial_quad_channel
    import dial_pkg::*;
#(
    parameter int unsigned JOY_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lhbl_fall,
    input  logic       spin_tog,
    input  logic       spin_dir,
    input  logic [6:0] joystick,
    output quad_t      dial
);

    localparam int unsigned DivW = (JOY_DIV > 1) ? $clog2(JOY_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(JOY_DIV - 1);

    quad_t           dial_q, dial_d;
    logic            last_q;
    logic [DivW-1:0] div_q, div_d;

    logic  spin_event;
    logic  btn_cw, btn_ccw, held, div_done;
    step_t step;

    always_comb begin
        spin_event = spin_tog != last_q;
        btn_cw     = ~joystick[6];
        btn_ccw    = ~joystick[5];
        // Both buttons or neither cancel each other and keep the divider parked
        held       = btn_cw ^ btn_ccw;
        div_done   = held && lhbl_fall && (div_q == DivMax);

        div_d = div_q;
        if (!held) begin
            div_d = '0;
        end else if (lhbl_fall) begin
            div_d = div_done ? '0 : div_q + 1'b1;
        end

        step = StepNone;
        if (spin_event) begin
            step = spin_dir ? StepCcw : StepCw;
        end else if (div_done) begin
            step = btn_cw ? StepCw : StepCcw;
        end

        dial_d = dial_q;
        case (step)
            StepCw:  dial_d = quad_next(dial_q);
            StepCcw: dial_d = quad_prev(dial_q);
            default: dial_d = dial_q;
        endcase
    end

    // Toggle tracker reloads from the live input so leaving reset never fakes an event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dial_q <= 2'b00;
            last_q <= spin_tog;
            div_q  <= '0;
        end else begin
            dial_q <= dial_d;
            last_q <= spin_tog;
            div_q  <= div_d;
        end
    end

    assign dial = dial_q;

endmodule

// File: rtl/dial_quad_encoder.sv
// Two-axis quadrature dial emulator for spinner and joystick inputs.
// Define DIAL_SPINNER_SYNC_EN to resynchronise spinner[8:7] through two flops (latency 3 clk).
module dial_quad_encoder
    import dial_pkg::*;
#(
    parameter int unsigned JOY_DIV = 8
) (
    input logic                clk,
    input logic                rst,
    dial_quad_encoder_if.slave bus
);

    logic lhbl_last_q;
    logic lhbl_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lhbl_last_q <= 1'b1;
        end else begin
            lhbl_last_q <= bus.LHBL;
        end
    end

    assign lhbl_fall = lhbl_last_q & ~bus.LHBL;

    logic [1:0] spin1, spin2;

`ifdef DIAL_SPINNER_SYNC_EN
    logic [1:0] spin1_meta_q, spin1_q;
    logic [1:0] spin2_meta_q, spin2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spin1_meta_q <= 2'b00;
            spin1_q      <= 2'b00;
            spin2_meta_q <= 2'b00;
            spin2_q      <= 2'b00;
        end else begin
            spin1_meta_q <= bus.spinner_1[8:7];
            spin1_q      <= spin1_meta_q;
            spin2_meta_q <= bus.spinner_2[8:7];
            spin2_q      <= spin2_meta_q;
        end
    end

    assign spin1 = spin1_q;
    assign spin2 = spin2_q;
`else
    assign spin1 = bus.spinner_1[8:7];
    assign spin2 = bus.spinner_2[8:7];
`endif

    dial_quad_channel #(
        .JOY_DIV(JOY_DIV)
    ) u_chan_x (
        .clk      (clk),
        .rst      (rst),
        .lhbl_fall(lhbl_fall),
        .spin_tog (spin1[1]),
        .spin_dir (spin1[0]),
        .joystick (bus.joystick1),
        .dial     (bus.dial_x)
    );

    dial_quad_channel #(
        .JOY_DIV(JOY_DIV)
    ) u_chan_y (
        .clk      (clk),
        .rst      (rst),
        .lhbl_fall(lhbl_fall),
        .spin_tog (spin2[1]),
        .spin_dir (spin2[0]),
        .joystick (bus.joystick2),
        .dial     (bus.dial_y)
    );

endmodule

// File: tb/tb_dial_quad_encoder.sv
// Scoreboard bench for dial_quad_encoder: directed scenarios then random spinner/joystick traffic.
module tb_dial_quad_encoder;

    localparam int unsigned JOY_DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dial_quad_encoder_if bus ();

    dial_quad_encoder #(
        .JOY_DIV(JOY_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase counters per axis, fall counts since press
    int         pos [2];
    bit         last8 [2];
    int         falls [2];
    bit         prev_lhbl;
    logic [1:0] exp_x [$];
    logic [1:0] exp_y [$];

    function automatic logic [1:0] quad_of(int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic check(string name, logic [1:0] act, logic [1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            pos[c]   = 0;
            falls[c] = 0;
        end
        last8[0]  = bus.spinner_1[8];
        last8[1]  = bus.spinner_2[8];
        prev_lhbl = 1'b1;
        exp_x.delete();
        exp_y.delete();
    endtask

    // Predict what the next rising edge does with the inputs currently driven
    task automatic model_edge();
        bit fall;
        fall = prev_lhbl && !bus.LHBL;
        for (int c = 0; c < 2; c++) begin
            logic [8:0] sp;
            logic [6:0] jy;
            bit         cw, ccw, jstep;
            int         delta;
            sp    = (c == 0) ? bus.spinner_1 : bus.spinner_2;
            jy    = (c == 0) ? bus.joystick1 : bus.joystick2;
            cw    = !jy[6];
            ccw   = !jy[5];
            jstep = 1'b0;
            delta = 0;
            if (cw == ccw) begin
                falls[c] = 0;
            end else if (fall) begin
                falls[c]++;
                jstep = (falls[c] % JOY_DIV) == 0;
            end
            if (sp[8] != last8[c]) begin
                last8[c] = sp[8];
                delta    = sp[7] ? -1 : 1;
            end else if (jstep) begin
                delta = cw ? 1 : -1;
            end
            if (delta != 0) begin
                pos[c] = (pos[c] + delta + 4) % 4;
                if (c == 0) exp_x.push_back(quad_of(pos[c]));
                else        exp_y.push_back(quad_of(pos[c]));
            end
        end
        prev_lhbl = bus.LHBL;
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic lhbl_falls(int n);
        for (int i = 0; i < n; i++) begin
            bus.LHBL = 1'b1;
            repeat (3) tick();
            bus.LHBL = 1'b0;
            tick();
        end
    endtask

    // Monitor: every change on a dial output must match the next queued expectation
    logic [1:0] seen_x = 2'b00;
    logic [1:0] seen_y = 2'b00;

    always @(negedge clk) begin
        if (rst) begin
            seen_x = bus.dial_x;
            seen_y = bus.dial_y;
        end else begin
            if (bus.dial_x !== seen_x) begin
                if (exp_x.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dial_x unexpected step: got %b, expected %b", bus.dial_x, seen_x);
                end else begin
                    check("dial_x step", bus.dial_x, exp_x.pop_front());
                end
                seen_x = bus.dial_x;
            end
            if (bus.dial_y !== seen_y) begin
                if (exp_y.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dial_y unexpected step: got %b, expected %b", bus.dial_y, seen_y);
                end else begin
                    check("dial_y step", bus.dial_y, exp_y.pop_front());
                end
                seen_y = bus.dial_y;
            end
        end
    end

    initial begin
        bus.LHBL      = 1'b0;
        bus.joystick1 = 7'h7f;
        bus.joystick2 = 7'h7f;
        bus.spinner_1 = 9'd0;
        bus.spinner_2 = 9'd0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check("reset dial_x", bus.dial_x, 2'b00);
        check("reset dial_y", bus.dial_y, 2'b00);
        rst = 1'b0;
        model_reset();

        // Idle with LHBL low
        repeat (1000) tick();
        check("idle dial_x", bus.dial_x, 2'b00);
        check("idle dial_y", bus.dial_y, 2'b00);

        // Spinner: 13 cw toggles, then 15 ccw
        for (int i = 0; i < 13; i++) begin
            bus.spinner_1 = {~bus.spinner_1[8], 1'b0, 7'd0};
            repeat (20) tick();
        end
        check("spin 13 cw", bus.dial_x, 2'b01);
        for (int i = 0; i < 15; i++) begin
            bus.spinner_1 = {~bus.spinner_1[8], 1'b1, 7'd0};
            repeat (20) tick();
        end
        check("spin net ccw", bus.dial_x, 2'b11);
        check("spin dial_y idle", bus.dial_y, 2'b00);

        // Joystick divider
        bus.joystick1 = 7'h3f;
        lhbl_falls(24);
        check("joy cw x3", bus.dial_x, 2'b01);
        bus.joystick1 = 7'h7f;
        tick();
        bus.joystick1 = 7'h5f;
        lhbl_falls(16);
        check("joy ccw x2", bus.dial_x, 2'b10);
        bus.joystick1 = 7'h1f;
        lhbl_falls(16);
        check("joy both held", bus.dial_x, 2'b10);
        bus.joystick1 = 7'h7f;
        bus.joystick2 = 7'h3f;
        lhbl_falls(8);
        check("joy2 cw", bus.dial_y, 2'b01);
        bus.joystick2 = 7'h7f;
        // Release must clear a partially counted divider
        bus.joystick1 = 7'h3f;
        lhbl_falls(5);
        bus.joystick1 = 7'h7f;
        tick();
        bus.joystick1 = 7'h3f;
        lhbl_falls(5);
        check("joy release clears", bus.dial_x, 2'b10);
        lhbl_falls(3);
        check("joy after re-press", bus.dial_x, 2'b00);
        bus.joystick1 = 7'h7f;
        tick();

        // Spinner ccw collides with the 8th-fall joystick cw step
        bus.joystick1 = 7'h3f;
        lhbl_falls(7);
        bus.LHBL = 1'b1;
        repeat (3) tick();
        bus.LHBL      = 1'b0;
        bus.spinner_1 = {~bus.spinner_1[8], 1'b1, 7'd0};
        tick();
        repeat (3) tick();
        check("spinner wins", bus.dial_x, 2'b10);
        bus.joystick1 = 7'h7f;
        repeat (4) tick();

        // Asynchronous reset mid-sequence
        #2 rst = 1'b1;
        #1 check("async reset x", bus.dial_x, 2'b00);
        check("async reset y", bus.dial_y, 2'b00);
        @(negedge clk);
        bus.spinner_1 = {~bus.spinner_1[8], 1'b0, 7'd0};
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (20) tick();
        check("no step after reset", bus.dial_x, 2'b00);

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            bus.LHBL = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 150) == 0)
                bus.joystick1 = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'h1f};
            if ($urandom_range(0, 150) == 0)
                bus.joystick2 = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'h1f};
            if ($urandom_range(0, 5) == 0)
                bus.spinner_1 = {~bus.spinner_1[8], $urandom_range(0, 1) == 1, 7'($urandom)};
            if ($urandom_range(0, 5) == 0)
                bus.spinner_2 = {~bus.spinner_2[8], $urandom_range(0, 1) == 1, 7'($urandom)};
            tick();
        end
        bus.joystick1 = 7'h7f;
        bus.joystick2 = 7'h7f;
        repeat (6) tick();
        check("final dial_x", bus.dial_x, quad_of(pos[0]));
        check("final dial_y", bus.dial_y, quad_of(pos[1]));
        vectors++;
        if (exp_x.size() != 0 || exp_y.size() != 0) begin
            miscompares++;
            $display("FAIL pending steps: got %0d/%0d outstanding, expected 0/0",
                     exp_x.size(), exp_y.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
